// File: rtl/tb_crc_sequencer_if.sv
// Handshake/bus bundle between a test sequencer and the test top that drives it.
// The master side requests runs and supplies DUT results; the slave side is the sequencer.
interface tb_crc_sequencer_if #(
   parameter int CRC_W = 64,
   parameter int CNT_W = 8
);
   logic             start;
   logic [CRC_W-1:0] result;
   logic [CRC_W-1:0] stim;
   logic [CRC_W-1:0] sum;
   logic [CNT_W-1:0] cyc;
   logic             busy;
   logic             done;
   logic             pass;

   modport master (
      output start, result,
      input  stim, sum, cyc, busy, done, pass
   );

   modport slave (
      input  start, result,
      output stim, sum, cyc, busy, done, pass
   );
endinterface

// File: rtl/tb_crc_sequencer.sv
// Stimulus LFSR plus signature accumulator for simulation test tops: runs a fixed number
// of cycles, folds DUT results into a signature and reports done/pass against a constant.
module tb_crc_sequencer #(
   parameter int          CRC_W   = 64,
   parameter logic [63:0] SEED    = 64'h5aef0c8d_d70a4497,
   parameter int          CYCLES  = 99,
   parameter int          WARMUP  = 10,
   parameter logic [63:0] EXP_SUM = 64'h0,
   parameter int          CNT_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   tb_crc_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT  = 3'd1,
      ST_RUN   = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam logic [CRC_W-1:0] SEED_C = SEED[CRC_W-1:0];
   localparam logic [CRC_W-1:0] EXP_C  = EXP_SUM[CRC_W-1:0];
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CYCLES - 1);
   localparam logic [CNT_W-1:0] WARM_C = CNT_W'(WARMUP);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

   // Shared by the stimulus generator and the signature fold: taps at MSB, bit 2 and bit 0.
   function automatic logic [CRC_W-1:0] lfsr_step(input logic [CRC_W-1:0] v);
      return {v[CRC_W-2:0], v[CRC_W-1] ^ v[2] ^ v[0]};
   endfunction

   state_e           state_q;
   logic [CRC_W-1:0] stim_q, stim_d;
   logic [CRC_W-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic             done_q;
   logic             pass_q;
   logic             busy_s;

   // Next values of the RUN-phase datapath.
   always_comb begin
      stim_d = lfsr_step(stim_q);
      sum_d  = bus.result ^ lfsr_step(sum_q);
      cyc_d  = cyc_q + ONE_C;
   end

   // Busy decode straight from the state register.
   always_comb begin
      busy_s = 1'b0;
      case (state_q)
         ST_INIT, ST_RUN, ST_CHECK: busy_s = 1'b1;
         default:                   busy_s = 1'b0;
      endcase
   end

   // Sequencer FSM with all datapath and status registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         stim_q  <= '0;
         sum_q   <= '0;
         cyc_q   <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) state_q <= ST_INIT;
               else           state_q <= ST_IDLE;
            end
            ST_INIT: begin
               stim_q  <= SEED_C;
               sum_q   <= '0;
               cyc_q   <= '0;
               done_q  <= 1'b0;
               pass_q  <= 1'b0;
               state_q <= ST_RUN;
            end
            ST_RUN: begin
               stim_q <= stim_d;
               cyc_q  <= cyc_d;
               if (cyc_q >= WARM_C) sum_q <= sum_d;
               else                 sum_q <= sum_q;
               // cyc is 2**CNT_W > CYCLES wide, so the final increment to CYCLES never wraps.
               if (cyc_q == LAST_C) state_q <= ST_CHECK;
               else                 state_q <= ST_RUN;
            end
            ST_CHECK: begin
               pass_q  <= (sum_q == EXP_C);
               done_q  <= 1'b1;
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               if (bus.start) state_q <= ST_INIT;
               else           state_q <= ST_DONE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.stim = stim_q;
   assign bus.sum  = sum_q;
   assign bus.cyc  = cyc_q;
   assign bus.busy = busy_s;
   assign bus.done = done_q;
   assign bus.pass = pass_q;

endmodule

// File: doc/tb_crc_sequencer.md
Name: tb_crc_sequencer

Overview:
Self-checking stimulus/checksum sequencer for simulation test tops.
- Drives an LFSR ("CRC") pattern into the design under test and folds the DUT's result into a running signature.
- After a fixed cycle count, compares the signature against an expected constant and raises done/pass.
- Sits directly upstream of the test's finish stage; that stage waits on done, then prints the completion banner and ends simulation.

Parameters:
CRC_W, 64, width of stimulus LFSR, result and signature; must be >= 3
SEED, 64'h5aef0c8d_d70a4497, LFSR value loaded on start (truncated to CRC_W)
CYCLES, 99, number of RUN cycles; must be >= 1
WARMUP, 10, RUN cycles before accumulation begins; must be < CYCLES
EXP_SUM, 64'h0, expected final signature (truncated to CRC_W)
CNT_W, 8, cycle counter width; 2**CNT_W must be > CYCLES

Ports:
clk  input  1  sole clock, all state updates on posedge
reset  input  1  asynchronous, active-high reset
start  input  1  level-sampled request to begin a run; honoured only in IDLE or DONE
result  input  CRC_W  DUT output, sampled every RUN cycle
stim  output  CRC_W  current LFSR value, registered
sum  output  CRC_W  running signature, registered
cyc  output  CNT_W  RUN cycle index, registered
busy  output  1  high in INIT, RUN and CHECK
done  output  1  high in DONE; stays high until the next start or reset
pass  output  1  valid while done is high; 1 = sum matched EXP_SUM

Behaviour:
- Reset (async assert, clean on deassert): state=IDLE; stim, sum, cyc, busy, done, pass all 0.
- States: IDLE, INIT, RUN, CHECK, DONE.
- IDLE: start=1 at an edge -> INIT.
- INIT (1 cycle): stim<=SEED, sum<=0, cyc<=0, done<=0, pass<=0 -> RUN.
- RUN, every edge:
  - stim <= {stim[CRC_W-2:0], stim[CRC_W-1]^stim[2]^stim[0]}.
  - cyc <= cyc+1.
  - If cyc >= WARMUP: sum <= result ^ {sum[CRC_W-2:0], sum[CRC_W-1]^sum[2]^sum[0]}.
  - Otherwise sum holds.
  - When cyc == CYCLES-1 -> CHECK; cyc then holds its final value.
- CHECK (1 cycle): pass <= (sum == EXP_SUM), done <= 1 -> DONE. stim and sum hold.
- DONE: all outputs hold; start=1 -> INIT, which clears done and pass.
- Latency: edge E samples start. done first reads 1 after edge E+CYCLES+2.
- Accumulation count: exactly CYCLES-WARMUP result samples are folded in.
- start during INIT, RUN or CHECK is ignored; there is no abort.
- busy is combinational from the state register; done and pass are registered.
- Reset mid-run returns to IDLE immediately and discards any partial signature.
- All arithmetic is modulo 2**CRC_W. The counter never wraps, since 2**CNT_W > CYCLES.

Test Plan:
1. CRC_W=8, SEED=8'h01, start pulse -> stim reads 8'h01, 8'h03, 8'h07, 8'h0E on successive RUN cycles.
2. CRC_W=8, CYCLES=1, WARMUP=0, result=8'hA5, EXP_SUM=8'hA5 -> sum=8'hA5; done=1 and pass=1 exactly 3 edges after the start edge.
3. Same as 2 with CYCLES=2, EXP_SUM=8'hEE -> sum goes 8'hA5 then 8'hEE; pass=1. Rerun with EXP_SUM=8'hEF -> done=1, pass=0.
4. Defaults, result tied to 0, EXP_SUM=0 -> sum stays 0 throughout; done=1 and pass=1 after 101 edges; busy high for 101 cycles.
5. Assert start continuously during RUN, then assert reset at cyc=5 -> start has no effect during RUN; on reset, all outputs read 0 at once and state is IDLE. A new start re-runs from SEED and gives the same sum as an uninterrupted run.
6. From DONE, pulse start -> done and pass drop after the next edge (INIT), a second identical run follows, and done returns with the same pass value.
